// File: rtl/pipeline_reg_file_pkg.sv
// Shared pipeline sizing used by every stage: register width, register
// count, PC width and the link-register index used by jump-and-link.
package pipeline_reg_file_pkg;

   localparam int RF_DSIZE = 32;
   localparam int RF_ASIZE = 5;
   localparam int RF_ISIZE = 32;

   // The link register is always the highest-numbered register.
   function automatic int link_reg(input int asize);
      return (1 << asize) - 1;
   endfunction

   localparam int RF_LINK_REG = link_reg(RF_ASIZE);

endpackage

// File: rtl/pipeline_reg_file_if.sv
// Writeback/decode-side signal bundle for the pipeline register file.
interface pipeline_reg_file_if
   import pipeline_reg_file_pkg::*;
#(
   parameter int DSIZE = RF_DSIZE,
   parameter int ASIZE = RF_ASIZE,
   parameter int ISIZE = RF_ISIZE
);
   logic             wen;
   logic [ASIZE-1:0] w_addr;
   logic [DSIZE-1:0] w_data;
   logic             jal;
   logic [ISIZE-1:0] PC;
   logic [ASIZE-1:0] r_addr_a;
   logic [ASIZE-1:0] r_addr_b;
   logic [DSIZE-1:0] r_data_a;
   logic [DSIZE-1:0] r_data_b;
   logic [15:0]      wr_count;

   modport master (
      output wen, w_addr, w_data, jal, PC, r_addr_a, r_addr_b,
      input  r_data_a, r_data_b, wr_count
   );

   modport slave (
      input  wen, w_addr, w_data, jal, PC, r_addr_a, r_addr_b,
      output r_data_a, r_data_b, wr_count
   );
endinterface

// File: rtl/pipeline_rf_bypass.sv
// One combinational read port: register 0 reads zero, otherwise a same-cycle
// committed write to the addressed register is forwarded ahead of storage.
module pipeline_rf_bypass #(
   parameter int DSIZE = 32,
   parameter int ASIZE = 5
) (
   input  logic [ASIZE-1:0] r_addr,
   input  logic [DSIZE-1:0] stored,
   input  logic             byp_en,
   input  logic [ASIZE-1:0] byp_addr,
   input  logic [DSIZE-1:0] byp_data,
   output logic [DSIZE-1:0] r_data
);

   always_comb begin
      r_data = stored;
      if (r_addr == '0)
         r_data = '0;
      else if (byp_en && (byp_addr == r_addr))
         r_data = byp_data;
   end

endmodule

// File: rtl/pipeline_reg_file.sv
// Pipeline register file: two bypassed read ports, one write port with
// jump-and-link override, and a count of committed writes.
module pipeline_reg_file
   import pipeline_reg_file_pkg::*;
#(
   parameter int DSIZE = RF_DSIZE,
   parameter int ASIZE = RF_ASIZE,
   parameter int ISIZE = RF_ISIZE
) (
   input logic                clk,
   input logic                rst,
   pipeline_reg_file_if.slave bus
);

   localparam int NREG = 1 << ASIZE;
   localparam logic [ASIZE-1:0] LINK = ASIZE'(link_reg(ASIZE));

   logic [DSIZE-1:0] regs [NREG];
   logic [ASIZE-1:0] wr_dst;
   logic [DSIZE-1:0] wr_val;
   logic [ISIZE-1:0] pc_next;
   logic             commit;
   logic [15:0]      count;

   // jal wins over the normal writeback path; PC+1 wraps at the PC width
   // before being resized to the register width.
   assign pc_next = bus.PC + ISIZE'(1);

   always_comb begin
      wr_dst = bus.w_addr;
      wr_val = bus.w_data;
      if (bus.jal) begin
         wr_dst = LINK;
         wr_val = DSIZE'(pc_next);
      end
   end

   // Writes to r0 are dropped; nothing commits (or bypasses) while in reset.
   assign commit = (bus.wen || bus.jal) && (wr_dst != '0) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         count <= '0;
      end else if (commit) begin
         regs[wr_dst] <= wr_val;
         count        <= count + 16'd1;
      end
   end

   assign bus.wr_count = count;

   pipeline_rf_bypass #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_port_a (
      .r_addr   (bus.r_addr_a),
      .stored   (regs[bus.r_addr_a]),
      .byp_en   (commit),
      .byp_addr (wr_dst),
      .byp_data (wr_val),
      .r_data   (bus.r_data_a)
   );

   pipeline_rf_bypass #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_port_b (
      .r_addr   (bus.r_addr_b),
      .stored   (regs[bus.r_addr_b]),
      .byp_en   (commit),
      .byp_addr (wr_dst),
      .byp_data (wr_val),
      .r_data   (bus.r_data_b)
   );

endmodule

// File: tb/tb_pipeline_reg_file.sv
// Directed and random stimulus for pipeline_reg_file against an array-based
// model of the register file, checked before every clock edge.
module tb_pipeline_reg_file;

   logic clk = 1'b0;
   logic rst;

   pipeline_reg_file_if #(.DSIZE(32), .ASIZE(5), .ISIZE(32)) bus ();

   pipeline_reg_file #(.DSIZE(32), .ASIZE(5), .ISIZE(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model [32];
   logic [15:0] model_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit hit,
                                            input logic [4:0] dst, input logic [31:0] val);
      if (addr == 5'd0)          return 32'd0;
      if (hit && dst == addr)    return val;
      return model[addr];
   endfunction

   // Drive one cycle with clk low, check combinational outputs, then clock it.
   task automatic step(input logic r, input logic w, input logic j,
                       input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input bit chk, input string tag);
      logic [4:0]  dst;
      logic [31:0] val;
      bit          hit;
      rst          = r;
      bus.wen      = w;
      bus.jal      = j;
      bus.w_addr   = wa;
      bus.w_data   = wd;
      bus.PC       = pc;
      bus.r_addr_a = ra;
      bus.r_addr_b = rb;
      dst = j ? 5'd31 : wa;
      val = j ? pc + 32'd1 : wd;
      hit = (w || j) && !r && (dst != 5'd0);
      #1;
      if (chk) begin
         check({tag, "_a"},   bus.r_data_a, exp_read(ra, hit, dst, val));
         check({tag, "_b"},   bus.r_data_b, exp_read(rb, hit, dst, val));
         check({tag, "_cnt"}, {16'd0, bus.wr_count}, {16'd0, model_count});
      end
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model[i] = 32'd0;
         model_count = 16'd0;
      end else if (hit) begin
         model[dst]  = val;
         model_count = model_count + 16'd1;
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_count = 16'd0;

      // Storage is unknown before the first reset edge.
      step(1, 1, 0, 5'd3, 32'h1234, 0, 5'd3, 5'd0, 0, "rst0");
      step(0, 0, 0, 5'd0, 0, 0, 5'd3, 5'd31, 1, "reset_state");

      step(0, 1, 0, 5'd3, 32'hDEADBEEF, 0, 5'd3, 5'd1, 1, "wr3_bypass");
      step(0, 0, 0, 5'd0, 0, 0, 5'd3, 5'd3, 1, "rd3");
      check("wr_count_1", {16'd0, bus.wr_count}, 32'd1);

      step(0, 1, 0, 5'd7, 32'h55, 0, 5'd7, 5'd7, 1, "wr7_dual_bypass");
      check("r7_before_edge_model", model[7], 32'h55);

      step(0, 1, 1, 5'd4, 32'h9, 32'h100, 5'd31, 5'd4, 1, "jal");
      step(0, 0, 0, 5'd0, 0, 0, 5'd31, 5'd4, 1, "jal_after");
      check("r31_link", bus.r_data_a, 32'h101);

      step(0, 1, 0, 5'd0, 32'hFFFF, 0, 5'd0, 5'd0, 1, "wr_r0");
      step(0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd3, 1, "rd_r0");
      step(0, 0, 1, 5'd2, 0, 32'hFFFFFFFF, 5'd31, 5'd2, 1, "jal_wrap");
      step(0, 0, 0, 5'd0, 0, 0, 5'd31, 5'd7, 1, "jal_wrap_after");
      check("r31_wrap_zero", bus.r_data_a, 32'h0);

      // Random traffic with occasional reset.
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
              5'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom), 1, "rand");
      end

      // Run the counter up to 0xFFFF, leaving r5=0x12 as the final write.
      while (model_count != 16'hFFFE)
         step(0, 1, 0, 5'($urandom_range(8, 30)), $urandom, 0, 5'd0, 5'd0, 0, "fill");
      step(0, 1, 0, 5'd5, 32'h12, 0, 5'd5, 5'd0, 1, "preload_r5");
      check("wr_count_ffff", {16'd0, bus.wr_count}, 32'h0000FFFF);
      step(0, 1, 0, 5'd6, 32'hA5, 0, 5'd5, 5'd6, 1, "count_wrap");
      check("wr_count_wrap", {16'd0, bus.wr_count}, 32'h0);
      check("r5_preloaded", bus.r_data_a, 32'h12);

      // Reset with a concurrent write: no bypass, write lost.
      step(1, 1, 0, 5'd5, 32'h77, 0, 5'd5, 5'd6, 1, "rst_mid");
      step(0, 0, 0, 5'd0, 0, 0, 5'd5, 5'd6, 1, "post_rst");
      check("r5_after_rst", bus.r_data_a, 32'h0);
      check("count_after_rst", {16'd0, bus.wr_count}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
